// File: rtl/img_sram_ctrl.sv
// img_sram_ctrl: access controller for the 256x256x8 image SRAM.
// Port A issues raster read/write bursts with an auto-incrementing (row, col) address;
// port B issues single-pixel reads. Requests are arbitrated round-robin in IDLE and every
// SRAM-side signal is registered, so address and enables only change on posedge clk.
// Optional feature macro:
//   IMG_SRAM_CTRL_PREEMPT_EN - a pending port B read may take a 2-cycle slot between A beats.
module img_sram_ctrl #(
  parameter int unsigned BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  // Port A: host burst loader/unloader
  input  logic               a_req,
  input  logic               a_we,
  input  logic [7:0]         a_row,
  input  logic [7:0]         a_col,
  input  logic [BURST_W-1:0] a_len,
  input  logic [7:0]         a_wdata,
  input  logic               a_wvalid,
  output logic               a_wready,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic               a_done,
  // Port B: convolution engine single reads
  input  logic               b_req,
  input  logic [7:0]         b_row,
  input  logic [7:0]         b_col,
  output logic               b_gnt,
  output logic               b_rvalid,
  // Shared read data
  output logic [7:0]         rdata,
  // SRAM master side
  output logic [7:0]         sram_row,
  output logic [7:0]         sram_col,
  output logic [7:0]         sram_din,
  output logic               sram_write_en,
  output logic               sram_sense_en,
  input  logic [7:0]         sram_dout,
  output logic               busy
);

  localparam int unsigned CntW = BURST_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StABurst,
    StBRd,
    StBSlot
  } state_e;

  state_e state_q, state_d;

  // Burst context
  logic [7:0]      row_q, row_d;
  logic [7:0]      col_q, col_d;
  logic            we_q, we_d;
  logic [CntW-1:0] left_q, left_d;    // beats not yet issued to the SRAM
  logic [1:0]      since_q, since_d;  // A beats issued since the last B slot, saturating at 2
  logic            last_b_q, last_b_d;
  logic            cool_q, cool_d;    // blocks grants for one cycle after a service
  logic            done_q, done_d;

  // Registered SRAM side
  logic [7:0] sram_row_q, sram_row_d;
  logic [7:0] sram_col_q, sram_col_d;
  logic [7:0] sram_din_q, sram_din_d;
  logic       sram_we_q, sram_we_d;
  logic       sram_se_q, sram_se_d;

  // Read pipeline: which port owns the read currently in the SRAM
  logic       rd_a_q, rd_a_d;
  logic       rd_b_q, rd_b_d;
  logic       a_rvalid_q, b_rvalid_q;
  logic [7:0] rdata_q;

  // Arbitration and beat-source signals
  logic            idle_ok;
  logic            pick_a, pick_b;
  logic            grant_a, grant_b;
  logic            slot;
  logic            a_phase;
  logic            beats_rem;
  logic            a_issue;
  logic            burst_end;
  logic [7:0]      row_eff, col_eff;
  logic            we_eff;
  logic [CntW-1:0] left_eff;

`ifdef IMG_SRAM_CTRL_PREEMPT_EN
  // B may cut in only while A still has beats to issue and after 2 A beats since the last slot.
  assign slot = (state_q == StABurst) && b_req && (left_q != '0) && (since_q == 2'd2);
`else
  assign slot = 1'b0;
`endif

  // Round-robin arbitration in IDLE; on a tie the port not served last wins.
  always_comb begin
    idle_ok = (state_q == StIdle) && !cool_q;
    pick_a  = a_req && (!b_req || last_b_q);
    pick_b  = b_req && (!a_req || !last_b_q);
    grant_a = idle_ok && pick_a;
    grant_b = idle_ok && pick_b;
  end

  // Beat source: in the grant cycle the burst context comes straight from the port inputs,
  // so the first beat can be issued at the posedge that ends the grant cycle.
  always_comb begin
    if (grant_a) begin
      row_eff  = a_row;
      col_eff  = a_col;
      we_eff   = a_we;
      left_eff = {1'b0, a_len} + CntW'(1);
      a_phase  = 1'b1;
    end else begin
      row_eff  = row_q;
      col_eff  = col_q;
      we_eff   = we_q;
      left_eff = left_q;
      a_phase  = (state_q == StABurst) && !slot;
    end
    beats_rem = (left_eff != '0);
    a_wready  = a_phase && we_eff && beats_rem;
    a_issue   = a_phase && beats_rem && (!we_eff || a_wvalid);
    burst_end = (state_q == StABurst) && (left_q == '0);
  end

  // Next-state FSM; a burst ends in the cycle holding its last beat.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cool_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_a) begin
          state_d = StABurst;
        end else if (grant_b) begin
          state_d = StBRd;
        end
      end
      StABurst: begin
        if (slot) begin
          state_d = StBSlot;
        end else if (burst_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cool_d  = 1'b1;
        end
      end
      StBRd: begin
        state_d = StIdle;
        cool_d  = 1'b1;
      end
      StBSlot: begin
        state_d = StABurst;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Burst context update: address wraps as one 16-bit {row, col} counter.
  always_comb begin
    {row_d, col_d} = {row_eff, col_eff};
    we_d           = we_eff;
    left_d         = left_eff;
    if (a_issue) begin
      {row_d, col_d} = {row_eff, col_eff} + 16'd1;
      left_d         = left_eff - CntW'(1);
    end

    since_d = since_q;
    if (grant_a) begin
      since_d = 2'd2;
    end else if (slot) begin
      since_d = 2'd0;
    end else if (a_issue && (since_q != 2'd2)) begin
      since_d = since_q + 2'd1;
    end

    last_b_d = last_b_q;
    if (grant_a) begin
      last_b_d = 1'b0;
    end else if (b_gnt) begin
      last_b_d = 1'b1;
    end
  end

  // SRAM command for the next cycle: A beat, B read, or Hold.
  always_comb begin
    sram_row_d = sram_row_q;
    sram_col_d = sram_col_q;
    sram_din_d = sram_din_q;
    sram_we_d  = 1'b0;
    sram_se_d  = 1'b1;
    rd_a_d     = 1'b0;
    rd_b_d     = 1'b0;
    if (a_issue) begin
      sram_row_d = row_eff;
      sram_col_d = col_eff;
      sram_we_d  = we_eff;
      sram_se_d  = we_eff;
      rd_a_d     = !we_eff;
      if (we_eff) begin
        sram_din_d = a_wdata;
      end
    end else if (b_gnt) begin
      sram_row_d = b_row;
      sram_col_d = b_col;
      sram_se_d  = 1'b0;
      rd_b_d     = 1'b1;
    end
  end

  // Control state; cool_q resets high so no grant is visible during or right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      we_q     <= 1'b0;
      left_q   <= '0;
      since_q  <= 2'd2;
      last_b_q <= 1'b1;
      cool_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      we_q     <= we_d;
      left_q   <= left_d;
      since_q  <= since_d;
      last_b_q <= last_b_d;
      cool_q   <= cool_d;
      done_q   <= done_d;
    end
  end

  // SRAM-side registers; reset drives Hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_row_q <= '0;
      sram_col_q <= '0;
      sram_din_q <= '0;
      sram_we_q  <= 1'b0;
      sram_se_q  <= 1'b1;
      rd_a_q     <= 1'b0;
      rd_b_q     <= 1'b0;
    end else begin
      sram_row_q <= sram_row_d;
      sram_col_q <= sram_col_d;
      sram_din_q <= sram_din_d;
      sram_we_q  <= sram_we_d;
      sram_se_q  <= sram_se_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
    end
  end

  // Read return: capture SRAM data at the posedge ending the read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      a_rvalid_q <= rd_a_q;
      b_rvalid_q <= rd_b_q;
      if (rd_a_q || rd_b_q) begin
        rdata_q <= sram_dout;
      end
    end
  end

  assign a_gnt         = grant_a;
  assign b_gnt         = grant_b || slot;
  assign a_done        = done_q;
  assign a_rvalid      = a_rvalid_q;
  assign b_rvalid      = b_rvalid_q;
  assign rdata         = rdata_q;
  assign sram_row      = sram_row_q;
  assign sram_col      = sram_col_q;
  assign sram_din      = sram_din_q;
  assign sram_write_en = sram_we_q;
  assign sram_sense_en = sram_se_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/img_sram_ctrl.md
# img_sram_ctrl

Access controller for the 256x256x8 image SRAM. It shares the SRAM between two requesters:
- port A (host loader/unloader): raster bursts, read or write, with auto-incrementing address.
- port B (convolution engine): single-pixel reads.

It arbitrates round-robin and registers every SRAM-side signal so that address and enables change only on posedge `clk`. It sits between the host/conv logic and the `img_sram_intf` master side.

## Interface
- `BURST_W`, default 16: width of `a_len`. 16 bits covers a full 65536-pixel frame.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `a_req` in 1: port A burst request, held until `a_gnt`.
- `a_we` in 1: 1 = write burst, 0 = read burst.
- `a_row`, `a_col` in 8 each: burst start address.
- `a_len` in BURST_W: beats minus 1.
- `a_wdata` in 8: write data.
- `a_wvalid` in 1: write data valid.
- `a_wready` out 1: write beat accepted on `a_wvalid & a_wready`.
- `a_gnt` out 1: one-cycle pulse when the burst is accepted.
- `a_rvalid` out 1: `rdata` belongs to port A.
- `a_done` out 1: one-cycle pulse after the last beat completes.
- `b_req` in 1: port B read request, held until `b_gnt`.
- `b_row`, `b_col` in 8 each: port B read address.
- `b_gnt` out 1: one-cycle pulse when the request is accepted.
- `b_rvalid` out 1: `rdata` belongs to port B.
- `rdata` out 8: registered read data, shared by A and B.
- `sram_row`, `sram_col`, `sram_din` out 8 each: registered SRAM address and write data.
- `sram_write_en`, `sram_sense_en` out 1 each: registered SRAM control.
- `sram_dout` in 8: SRAM read data, valid at posedge ending the read cycle.
- `busy` out 1: state is not IDLE.

## Operation
- SRAM op encoding:
  - Write: `write_en=1, sense_en=1`.
  - Read: `0,0`.
  - Hold: `0,1`. Hold is driven in every cycle without a beat.
- States:
  - IDLE → A_BURST on A grant.
  - IDLE → B_RD on B grant.
  - A_BURST → IDLE after the last beat.
  - B_RD → IDLE after its single read.
- Arbitration in IDLE:
  - A single requester wins.
  - If both request, the winner is the port not served last.
  - The pointer resets to "B served last", so A wins the first tie.
- Grant cycle: gnt pulses; controller latches address, `a_len`, `a_we`; SRAM is in Hold.
- A read burst: one beat per cycle, starting the cycle after `a_gnt`.
- A write burst:
  - `a_wready=1` from the `a_gnt` cycle while beats remain, except in a preemption slot.
  - Each handshake at a posedge produces one write beat in the next cycle.
  - A cycle without a handshake inserts Hold; the address does not advance.
- Address advance after each beat:
  - col+1.
  - col 255 → 0 with row+1.
  - (255,255) → (0,0).
  - Arithmetic is modulo 256 per field.
- Beat counter counts `a_len+1` beats; then `a_done` pulses in the cycle after the last beat and the state returns to IDLE.
  - For reads, `a_done` coincides with the last `a_rvalid`.
- Port B: `b_gnt` cycle, read cycle, then `b_rvalid` in the following cycle.
- Reset, asynchronous and valid mid-burst:
  - State returns to IDLE; in-flight beats are dropped.
  - All outputs go to 0, except `sram_sense_en=1` (Hold).

## Timing
- Read latency: beat driven in cycle N; `rdata`/`*_rvalid` are high in cycle N+1.
- Write: data handshaked at the posedge starting cycle N is written during clk-low of cycle N.
- Back-to-back: after `a_done` or the B read, return to IDLE. A new grant is possible in the next cycle.
- Minimum idle between grants: 1 cycle.
- Requests deasserted before gnt are dropped; gnt is never issued for a non-requesting port.

## Configuration
- `IMG_SRAM_CTRL_PREEMPT_EN` defined:
  - During A_BURST, a pending `b_req` is served in a single slot between A beats.
  - Slot sequence: `b_gnt` pulse, then the B read in the next cycle (2 cycles total).
  - During the slot: A beat counter and address are frozen, and `a_wready=0`.
  - After a slot, at least 2 A beats (or burst end) occur before the next slot.
- Undefined: B waits until A_BURST ends and is then served by normal arbitration.

## Test plan
- Reset mid read burst:
  - Outputs go to 0; `sram_write_en=0`, `sram_sense_en=1`.
  - `busy=0`; no `a_done`.
- A write, start (0,254), `a_len=3`, data 0x11,0x22,0x33,0x44, `a_wvalid` held high:
  - Writes go to (0,254), (0,255), (1,0), (1,1).
  - `a_done` pulses 5 cycles after `a_gnt`.
- Same write with `a_wvalid` low for 2 cycles after beat 1:
  - 2 Hold cycles inserted; address stays at (0,255).
  - `a_done` is delayed by 2 cycles.
- A read at (255,255), `a_len=1`, SRAM model returns 0xAB, 0xCD:
  - Addresses (255,255), (0,0).
  - `a_rvalid` is high in gnt+2 and gnt+3 with `rdata`=0xAB, 0xCD.
- `a_req` and `b_req` in the same cycle after reset, both re-asserted after service:
  - A served first, then B; on the next tie, A.
  - With `IMG_SRAM_CTRL_PREEMPT_EN`, `b_req` during an A read `a_len=7` gets `b_gnt` after beat 1. `b_rvalid` follows 2 cycles after `b_gnt`, and the A burst completes all 8 beats.
